// File: rtl/uart_core.sv
// Full-duplex UART core: shared oversampling tick generator, TX with one holding register,
// RX with a two-flop input synchronizer, mid-bit sampling and per-frame status flags.
module uart_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          baud_div,
    input  logic                 ld_tx_data,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_enable,
    output logic                 tx_out,
    output logic                 tx_empty,
    output logic                 tx_over_run,
    input  logic                 rx_in,
    input  logic                 rx_enable,
    input  logic                 uld_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_over_run
);

    localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] OS_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] DB_LAST = 3'(DATA_BITS - 1);
    localparam logic       SB_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} state_t;

    // ---------------- sample tick generator ----------------
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] div_q, div_d;
    logic        tick;

    // The divisor is only picked up at a wrap so a change never produces a short period.
    always_comb begin
        tick       = (baud_cnt_q == div_q);
        baud_cnt_d = tick ? 16'd0 : baud_cnt_q + 16'd1;
        div_d      = tick ? baud_div : div_q;
    end

    // ---------------- transmitter ----------------
    state_t                 tx_state_q, tx_state_d;
    logic [3:0]             tx_tick_q, tx_tick_d;
    logic [2:0]             tx_bit_q, tx_bit_d;
    logic                   tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0]   tx_hold_q, tx_hold_d;
    logic                   tx_empty_q, tx_empty_d;
    logic                   tx_ovr_q, tx_ovr_d;
    logic                   tx_out_q, tx_out_d;
    logic                   tx_done, tx_bit_end, tx_par_bit, tx_accept;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_hold_d  = tx_hold_q;
        tx_empty_d = tx_empty_q;
        tx_ovr_d   = tx_ovr_q;
        tx_out_d   = 1'b1;
        tx_done    = 1'b0;
        tx_bit_end = tick && (tx_tick_q == OS_LAST);
        tx_par_bit = (PARITY == 2) ? ~^tx_hold_q : ^tx_hold_q;

        if (tick) tx_tick_d = tx_tick_q + 4'd1;

        if (!tx_enable) begin
            tx_state_d = ST_IDLE;
            tx_tick_d  = 4'd0;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    tx_tick_d = 4'd0;
                    if (tick && !tx_empty_q) tx_state_d = ST_START;
                end
                ST_START: if (tx_bit_end) begin
                    tx_state_d = ST_DATA;
                    tx_tick_d  = 4'd0;
                    tx_bit_d   = 3'd0;
                end
                ST_DATA: if (tx_bit_end) begin
                    tx_tick_d = 4'd0;
                    if (tx_bit_q == DB_LAST) begin
                        tx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                        tx_stop_d  = 1'b0;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
                ST_PAR: if (tx_bit_end) begin
                    tx_state_d = ST_STOP;
                    tx_tick_d  = 4'd0;
                    tx_stop_d  = 1'b0;
                end
                ST_STOP: if (tx_bit_end) begin
                    tx_tick_d = 4'd0;
                    if (tx_stop_q == SB_LAST) begin
                        tx_state_d = ST_IDLE;
                        tx_done    = 1'b1;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
                default: tx_state_d = ST_IDLE;
            endcase
        end

        // The register frees up on the final stop tick, so a load in that cycle is legal.
        tx_accept = ld_tx_data && (tx_empty_q || tx_done);
        if (tx_done) tx_empty_d = 1'b1;
        if (tx_accept) begin
            tx_hold_d  = tx_data;
            tx_empty_d = 1'b0;
            tx_ovr_d   = 1'b0;
        end else if (ld_tx_data) begin
            tx_ovr_d = 1'b1;
        end

        case (tx_state_d)
            ST_START: tx_out_d = 1'b0;
            ST_DATA:  tx_out_d = tx_hold_q[tx_bit_d];
            ST_PAR:   tx_out_d = tx_par_bit;
            default:  tx_out_d = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    logic                   rx_meta_q, rx_sync_q;
    state_t                 rx_state_q, rx_state_d;
    logic [3:0]             rx_tick_q, rx_tick_d;
    logic [2:0]             rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0]   rx_hold_q, rx_hold_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_empty_q, rx_empty_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_ovr_q, rx_ovr_d;
    logic                   rx_done, rx_sample, rx_exp_par;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_hold_d  = rx_hold_q;
        rx_data_d  = rx_data_q;
        rx_empty_d = rx_empty_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_ovr_d   = rx_ovr_q;
        rx_done    = 1'b0;
        rx_sample  = tick && (rx_tick_q == OS_LAST);
        rx_exp_par = (PARITY == 2) ? ~^rx_shift_q : ^rx_shift_q;

        if (tick) rx_tick_d = rx_tick_q + 4'd1;

        if (!rx_enable) begin
            rx_state_d = ST_IDLE;
            rx_tick_d  = 4'd0;
        end else begin
            case (rx_state_q)
                ST_IDLE: begin
                    rx_tick_d = 4'd0;
                    if (tick && !rx_sync_q) rx_state_d = ST_START;
                end
                // Re-align the tick counter to mid-bit so later samples land at bit centres.
                ST_START: if (tick && (rx_tick_q == OS_MID)) begin
                    rx_tick_d  = 4'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (rx_sample) begin
                    rx_tick_d  = 4'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DB_LAST) rx_state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    else                     rx_bit_d   = rx_bit_q + 3'd1;
                end
                ST_PAR: if (rx_sample) begin
                    rx_tick_d  = 4'd0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = ST_STOP;
                end
                ST_STOP: if (rx_sample) begin
                    rx_tick_d  = 4'd0;
                    rx_state_d = ST_IDLE;
                    rx_done    = 1'b1;
                end
                default: rx_state_d = ST_IDLE;
            endcase
        end

        if (uld_rx_data) begin
            rx_data_d  = rx_hold_q;
            rx_empty_d = 1'b1;
        end
        if (rx_done) begin
            rx_hold_d  = rx_shift_q;
            rx_empty_d = 1'b0;
            rx_ferr_d  = !rx_sync_q;
            rx_perr_d  = (PARITY != 0) && (rx_par_q != rx_exp_par);
            rx_ovr_d   = !rx_empty_q && !uld_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
            div_q      <= '0;
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_hold_q  <= '0;
            tx_empty_q <= 1'b1;
            tx_ovr_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_hold_q  <= '0;
            rx_data_q  <= '0;
            rx_empty_q <= 1'b1;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_hold_q  <= tx_hold_d;
            tx_empty_q <= tx_empty_d;
            tx_ovr_q   <= tx_ovr_d;
            tx_out_q   <= tx_out_d;
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_hold_q  <= rx_hold_d;
            rx_data_q  <= rx_data_d;
            rx_empty_q <= rx_empty_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign tx_out        = tx_out_q;
    assign tx_empty      = tx_empty_q;
    assign tx_over_run   = tx_ovr_q;
    assign rx_data       = rx_data_q;
    assign rx_empty      = rx_empty_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_over_run   = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: a default-parameter instance and an even-parity instance, both at
// baud_div=3 (64 clk per bit). Received bytes are checked against a per-instance scoreboard.
module tb_uart_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] baud = 16'd3;

    // default instance (suffix _d) and parity instance (suffix _p)
    logic       rst_d, ld_d, txen_d, txo_d, txe_d, txovr_d, rxi_d, rxen_d, uld_d;
    logic       rxe_d, fe_d, pe_d, oe_d, drv_d, loop_d;
    logic [7:0] txd_d, rxdata_d;
    logic       rst_p, ld_p, txen_p, txo_p, txe_p, txovr_p, rxi_p, rxen_p, uld_p;
    logic       rxe_p, fe_p, pe_p, oe_p, drv_p, loop_p;
    logic [7:0] txd_p, rxdata_p;

    assign rxi_d = loop_d ? txo_d : drv_d;
    assign rxi_p = loop_p ? txo_p : drv_p;

    uart_core u_dflt (
        .clk(clk), .reset(rst_d), .baud_div(baud), .ld_tx_data(ld_d), .tx_data(txd_d),
        .tx_enable(txen_d), .tx_out(txo_d), .tx_empty(txe_d), .tx_over_run(txovr_d),
        .rx_in(rxi_d), .rx_enable(rxen_d), .uld_rx_data(uld_d), .rx_data(rxdata_d),
        .rx_empty(rxe_d), .rx_frame_err(fe_d), .rx_parity_err(pe_d), .rx_over_run(oe_d)
    );

    uart_core #(.PARITY(1)) u_par (
        .clk(clk), .reset(rst_p), .baud_div(baud), .ld_tx_data(ld_p), .tx_data(txd_p),
        .tx_enable(txen_p), .tx_out(txo_p), .tx_empty(txe_p), .tx_over_run(txovr_p),
        .rx_in(rxi_p), .rx_enable(rxen_p), .uld_rx_data(uld_p), .rx_data(rxdata_p),
        .rx_empty(rxe_p), .rx_frame_err(fe_p), .rx_parity_err(pe_p), .rx_over_run(oe_p)
    );

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       oerr;
    } exp_t;

    exp_t q_d[$];
    exp_t q_p[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input bit sel, input logic [7:0] data, input logic ferr,
                        input logic perr, input logic oerr);
        exp_t e;
        e.data = data; e.ferr = ferr; e.perr = perr; e.oerr = oerr;
        if (sel) q_p.push_back(e);
        else     q_d.push_back(e);
    endtask

    task automatic drive_bit(input bit sel, input logic b, input int n);
        if (sel) drv_p = b;
        else     drv_d = b;
        repeat (n) @(negedge clk);
    endtask

    // Bit-banged frame: start, LSB-first data, optional parity, stop (a low stop is held short).
    task automatic send_frame(input bit sel, input logic [7:0] data, input bit has_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0, 64);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i], 64);
        if (has_par) drive_bit(sel, par, 64);
        drive_bit(sel, stop, stop ? 64 : 40);
        drive_bit(sel, 1'b1, 64);
    endtask

    task automatic tx_load(input bit sel, input logic [7:0] data);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sel ? txe_p : txe_d) begin ok = 1'b1; break; end
        end
        check("tx_ready", 32'(ok), 32'd1);
        if (sel) begin txd_p = data; ld_p = 1'b1; end
        else     begin txd_d = data; ld_d = 1'b1; end
        @(negedge clk);
        ld_p = 1'b0; ld_d = 1'b0;
        check("tx_empty_clr", 32'(sel ? txe_p : txe_d), 32'd0);
    endtask

    task automatic rx_expect(input bit sel);
        bit   ok = 1'b0;
        exp_t e;
        for (int i = 0; i < 3000; i++) begin
            if (!(sel ? rxe_p : rxe_d)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("rx_arrive", 32'(ok), 32'd1);
        e = sel ? q_p.pop_front() : q_d.pop_front();
        if (ok) begin
            check("rx_ferr", 32'(sel ? fe_p : fe_d), 32'(e.ferr));
            check("rx_perr", 32'(sel ? pe_p : pe_d), 32'(e.perr));
            check("rx_oerr", 32'(sel ? oe_p : oe_d), 32'(e.oerr));
            if (sel) uld_p = 1'b1; else uld_d = 1'b1;
            @(negedge clk);
            uld_p = 1'b0; uld_d = 1'b0;
            check("rx_data", 32'(sel ? rxdata_p : rxdata_d), 32'(e.data));
            check("rx_empty_set", 32'(sel ? rxe_p : rxe_d), 32'd1);
            $display("rx%0d byte %02h fe=%0b pe=%0b oe=%0b", sel, e.data, e.ferr, e.perr, e.oerr);
        end
    endtask

    task automatic wait_fall_d(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!txo_d) begin ok = 1'b1; break; end
        end
        check("tx_start", 32'(ok), 32'd1);
    endtask

    initial begin
        logic [7:0] a5 = 8'hA5;
        logic [9:0] frame_bits;
        bit         ok;
        int         hi_at, e_at;
        logic [7:0] pbytes [3] = '{8'h00, 8'hFF, 8'h5A};

        rst_d = 1'b1; ld_d = 1'b0; txd_d = '0; txen_d = 1'b1; rxen_d = 1'b1; uld_d = 1'b0;
        drv_d = 1'b1; loop_d = 1'b0;
        rst_p = 1'b1; ld_p = 1'b0; txd_p = '0; txen_p = 1'b1; rxen_p = 1'b1; uld_p = 1'b0;
        drv_p = 1'b1; loop_p = 1'b0;
        repeat (3) @(negedge clk);
        rst_d = 1'b0; rst_p = 1'b0;
        @(negedge clk);
        check("rst_tx_out", 32'(txo_d), 32'd1);
        check("rst_tx_empty", 32'(txe_d), 32'd1);
        check("rst_rx_empty", 32'(rxe_d), 32'd1);
        check("rst_rx_data", 32'(rxdata_d), 32'd0);
        check("rst_flags", 32'({txovr_d, fe_d, pe_d, oe_d}), 32'd0);

        // 0xA5 waveform: sample each bit at its centre and time the start bit and tx_empty
        tx_load(1'b0, a5);
        frame_bits = {1'b1, a5, 1'b0};
        wait_fall_d(ok);
        hi_at = 0; e_at = 0;
        if (ok) begin
            for (int k = 1; k <= 700; k++) begin
                @(negedge clk);
                if (hi_at == 0 && txo_d) hi_at = k;
                if (e_at == 0 && txe_d) e_at = k;
                for (int i = 0; i < 10; i++)
                    if (k == 32 + 64 * i) check($sformatf("tx_bit%0d", i), 32'(txo_d), 32'(frame_bits[i]));
            end
            check("tx_start_len", 32'(hi_at), 32'd64);
            check("tx_empty_time", 32'(e_at), 32'd640);
            $display("tx byte a5 start_len=%0d empty_after=%0d", hi_at, e_at);
        end

        // overrun on a busy load, then reset in the middle of data bit 3
        tx_load(1'b0, 8'hC3);
        ld_d = 1'b1; txd_d = 8'hFF;
        @(negedge clk);
        ld_d = 1'b0;
        check("tx_overrun", 32'(txovr_d), 32'd1);
        wait_fall_d(ok);
        repeat (64 * 4 + 20) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        check("midrst_tx_out", 32'(txo_d), 32'd1);
        check("midrst_tx_empty", 32'(txe_d), 32'd1);
        check("midrst_overrun", 32'(txovr_d), 32'd0);
        loop_d = 1'b1;
        push(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        tx_load(1'b0, 8'h3C);
        rx_expect(1'b0);
        repeat (100) @(negedge clk);
        loop_d = 1'b0;

        // framing error, then a clean frame clears it
        push(1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        rx_expect(1'b0);
        push(1'b0, 8'h4C, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 8'h4C, 1'b0, 1'b0, 1'b1);
        rx_expect(1'b0);

        // two frames without unload
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        check("rx_first_held", 32'(rxe_d), 32'd0);
        push(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        rx_expect(1'b0);

        // 4-tick glitch on the line must not start a frame
        drive_bit(1'b0, 1'b0, 16);
        drive_bit(1'b0, 1'b1, 800);
        check("glitch_rx_empty", 32'(rxe_d), 32'd1);
        $display("glitch rx_empty=%0b", rxe_d);

        // even parity loopback, then wrong and right parity bit-banged
        loop_p = 1'b1;
        foreach (pbytes[i]) begin
            push(1'b1, pbytes[i], 1'b0, 1'b0, 1'b0);
            tx_load(1'b1, pbytes[i]);
            rx_expect(1'b1);
        end
        repeat (100) @(negedge clk);
        loop_p = 1'b0;
        push(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(1'b1, 8'h5A, 1'b1, ~(^a5 ^ 1'b0) ^ ^8'h5A ^ ^a5, 1'b1);
        rx_expect(1'b1);
        push(1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(1'b1, 8'h96, 1'b1, 1'b0, 1'b1);
        rx_expect(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_core.md
UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter PARITY, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1..2).
REQ-004 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (legal 8 or 16).
REQ-005 SHALL have port clk  input  1  single clock for TX and RX.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port baud_div  input  16  sample-tick period minus one, in clk cycles.
REQ-008 SHALL have port ld_tx_data  input  1  load tx_data into TX holding register.
REQ-009 SHALL have port tx_data  input  DATA_BITS  byte to transmit.
REQ-010 SHALL have port tx_enable  input  1  TX enable.
REQ-011 SHALL have port tx_out  output  1  serial output, idle high.
REQ-012 SHALL have port tx_empty  output  1  TX holding register free.
REQ-013 SHALL have port tx_over_run  output  1  load attempted while not empty (sticky).
REQ-014 SHALL have port rx_in  input  1  asynchronous serial input.
REQ-015 SHALL have port rx_enable  input  1  RX enable.
REQ-016 SHALL have port uld_rx_data  input  1  unload received byte.
REQ-017 SHALL have port rx_data  output  DATA_BITS  received byte, updated on uld_rx_data.
REQ-018 SHALL have port rx_empty  output  1  no unread byte.
REQ-019 SHALL have ports rx_frame_err, rx_parity_err, rx_over_run  output  1 each  status of last completed frame.

Function
REQ-020 SHALL generate one sample tick every baud_div+1 clk cycles from a free-running counter; baud_div=0 gives a tick every cycle; baud_div change takes effect at next counter wrap.
REQ-021 TX SHALL use states IDLE, START, DATA, PAR, STOP; each bit lasts exactly OVERSAMPLE ticks; PAR skipped when PARITY=0; STOP lasts STOP_BITS bit times.
REQ-022 ld_tx_data with tx_empty=1 SHALL capture tx_data and clear tx_empty next cycle; with tx_empty=0 SHALL be ignored and set tx_over_run, which clears on the next accepted load.
REQ-023 TX SHALL leave IDLE on the first tick with tx_enable=1 and tx_empty=0; data sent LSB first; parity bit = XOR of data (even) or its inverse (odd).
REQ-024 tx_empty SHALL return to 1 on the last tick of the final stop bit; a load in that same cycle SHALL be accepted.
REQ-025 tx_enable deasserted mid-frame SHALL force tx_out=1 and state IDLE next cycle, keeping the held byte (tx_empty stays 0); re-enable restarts from START.
REQ-026 RX SHALL pass rx_in through a two-flop synchronizer (reset value 1) before any use.
REQ-027 RX states IDLE, START, DATA, PAR, STOP; start detected when synchronized input low on a tick in IDLE with rx_enable=1.
REQ-028 RX SHALL sample each bit at tick OVERSAMPLE/2 of its bit period; a START sample reading 1 SHALL return to IDLE with no flags changed (glitch rejection).
REQ-029 Only the first stop bit SHALL be checked; returns to IDLE after it is sampled.
REQ-030 At frame end RX SHALL: store shift register in holding register, clear rx_empty, set rx_frame_err if stop=0, set rx_parity_err on parity mismatch (0 when PARITY=0), set rx_over_run if rx_empty was 0 and uld_rx_data not asserted that cycle; all flags rewritten every frame.
REQ-031 A frame with frame error SHALL still be stored and clear rx_empty.
REQ-032 uld_rx_data SHALL copy holding register to rx_data and set rx_empty=1 next cycle; if a frame completes the same cycle, rx_data gets the old byte and rx_empty ends 0.
REQ-033 rx_enable deasserted SHALL return RX to IDLE next cycle, discarding the partial frame without flag changes.

Reset
REQ-034 On reset at a clk edge, all state SHALL clear regardless of operation in progress: tx_out=1, tx_empty=1, rx_empty=1, rx_data=0, all error flags 0, both FSMs IDLE, baud counter 0.

Verification
REQ-035 baud_div=3, defaults, load 0xA5 -> tx_out low 64 clks, then 1,0,1,0,0,1,0,1 at 64 clks each, then high; tx_empty=1 after 640 clks.
REQ-036 TX looped to RX, PARITY=1, bytes 0x00,0xFF,0x5A -> each received with rx_parity_err=0; forced wrong parity bit -> rx_parity_err=1.
REQ-037 Stop bit driven 0 -> rx_frame_err=1, rx_empty=0; next good frame clears it.
REQ-038 Two frames without uld_rx_data -> rx_over_run=1, rx_data after unload = second byte.
REQ-039 rx_in low pulse of 4 ticks (OVERSAMPLE=16) -> no frame, rx_empty stays 1.
REQ-040 reset asserted mid-TX bit 3 -> tx_out=1, tx_empty=1 the next cycle; subsequent load transmits normally.
